// File: rtl/debug_hex_overlay.sv
// On-screen hex debug overlay: CHANNELS rows of DIGITS hex glyphs (8x8) mixed over 24-bit video.
// Snapshots are taken at the vblank rising edge; the pixel path is a fixed 3-clock pipe.
module debug_hex_overlay #(
  parameter int          CHANNELS    = 4,
  parameter int          DIGITS      = 16,
  parameter int          X0          = 16,
  parameter int          Y0          = 16,
  parameter logic [23:0] FG_COLOR    = 24'hFFC000,
  parameter logic [23:0] HL_COLOR    = 24'hFF4040,
  parameter logic [23:0] BG_COLOR    = 24'h000040,
  parameter int          HOLD_FRAMES = 30
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_enable,
  input  logic                         i_freeze,
  input  logic                         i_ce_pix,
  input  logic [11:0]                  i_h,
  input  logic [11:0]                  i_v,
  input  logic                         i_vblank,
  input  logic [23:0]                  i_rgb,
  input  logic [CHANNELS*DIGITS*4-1:0] i_debug,
  output logic                         o_ce_pix,
  output logic [23:0]                  o_rgb
);

  localparam int WORD_W = DIGITS * 4;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [12:0]       X0_C      = 13'(X0);
  localparam logic [12:0]       Y0_C      = 13'(Y0);
  localparam logic [12:0]       REG_W_C   = 13'(DIGITS * 8);
  localparam logic [12:0]       REG_H_C   = 13'(CHANNELS * 8);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);

  // Row byte of the 8x8 glyph for a hex nibble; row 0 is in the top byte, bit 7 = leftmost pixel.
  function automatic logic [7:0] font_row(input logic [3:0] nib, input logic [2:0] row);
    logic [63:0] g;
    case (nib)
      4'h0:    g = 64'h3C666E7666663C00;
      4'h1:    g = 64'h1838181818187E00;
      4'h2:    g = 64'h3C66060C30607E00;
      4'h3:    g = 64'h3C66061C06663C00;
      4'h4:    g = 64'h0C1C3C6C7E0C0C00;
      4'h5:    g = 64'h7E607C0606663C00;
      4'h6:    g = 64'h3C607C6666663C00;
      4'h7:    g = 64'h7E060C1830303000;
      4'h8:    g = 64'h3C66663C66663C00;
      4'h9:    g = 64'h3C66663E060C3800;
      4'hA:    g = 64'h183C66667E666600;
      4'hB:    g = 64'h7C66667C66667C00;
      4'hC:    g = 64'h3C66606060663C00;
      4'hD:    g = 64'h786C6666666C7800;
      4'hE:    g = 64'h7E60607C60607E00;
      4'hF:    g = 64'h7E60607C60606000;
      default: g = 64'h0000000000000000;
    endcase
    font_row = g[{~row, 3'b000} +: 8];
  endfunction

  logic [WORD_W-1:0] snap_r [CHANNELS];
  logic [HOLD_W-1:0] hold_r [CHANNELS];
  logic              vblank_d_r;
  logic              vblank_rise_s;

  logic [12:0] dx_s;
  logic [12:0] dy_s;
  logic        in_region_s;

  logic            in_region_1_r;
  logic [CH_W-1:0] ch_1_r;
  logic [DG_W-1:0] digit_1_r;
  logic [2:0]      gcol_1_r;
  logic [2:0]      grow_1_r;
  logic [23:0]     rgb_1_r;
  logic            ce_1_r;
  logic            en_1_r;

  logic [WORD_W-1:0] word_s;
  logic [3:0]        nibble_s;
  logic              hl_s;

  logic        in_region_2_r;
  logic [7:0]  rowbyte_2_r;
  logic        hl_2_r;
  logic [2:0]  gcol_2_r;
  logic [23:0] rgb_2_r;
  logic        ce_2_r;
  logic        en_2_r;

  assign vblank_rise_s = i_vblank & ~vblank_d_r;

  // Snapshot and highlight-hold update on the vblank rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Track vblank during reset so an edge seen while in reset is not replayed afterwards.
      vblank_d_r <= i_vblank;
      for (int c = 0; c < CHANNELS; c++) begin
        snap_r[c] <= '0;
        hold_r[c] <= '0;
      end
    end else begin
      vblank_d_r <= i_vblank;
      if (vblank_rise_s && !i_freeze) begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (snap_r[c] != i_debug[c*WORD_W +: WORD_W]) begin
            snap_r[c] <= i_debug[c*WORD_W +: WORD_W];
            hold_r[c] <= HOLD_INIT;
          end else if (hold_r[c] != '0) begin
            hold_r[c] <= hold_r[c] - HOLD_W'(1);
          end else begin
            hold_r[c] <= hold_r[c];
          end
        end
      end else begin
        vblank_d_r <= i_vblank;
      end
    end
  end

  // Text-block geometry; 13-bit subtraction makes positions left/above the block negative.
  always_comb begin
    dx_s        = {1'b0, i_h} - X0_C;
    dy_s        = {1'b0, i_v} - Y0_C;
    in_region_s = !dx_s[12] && (dx_s < REG_W_C) && !dy_s[12] && (dy_s < REG_H_C);
  end

  // Stage 1: register cell coordinates and the side-band signals.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_region_1_r <= 1'b0;
      ch_1_r        <= '0;
      digit_1_r     <= '0;
      gcol_1_r      <= 3'd0;
      grow_1_r      <= 3'd0;
      rgb_1_r       <= 24'd0;
      ce_1_r        <= 1'b0;
      en_1_r        <= 1'b0;
    end else begin
      in_region_1_r <= in_region_s;
      ch_1_r        <= dy_s[CH_W+2:3];
      digit_1_r     <= dx_s[DG_W+2:3];
      gcol_1_r      <= dx_s[2:0];
      grow_1_r      <= dy_s[2:0];
      rgb_1_r       <= i_rgb;
      ce_1_r        <= i_ce_pix;
      en_1_r        <= i_enable;
    end
  end

  // Channel word, nibble and highlight selection for stage 2.
  always_comb begin
    word_s   = '0;
    nibble_s = 4'd0;
    hl_s     = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      word_s = (ch_1_r == CH_W'(c)) ? snap_r[c] : word_s;
      hl_s   = (ch_1_r == CH_W'(c)) ? (hold_r[c] != '0) : hl_s;
    end
    for (int d = 0; d < DIGITS; d++) begin
      nibble_s = (digit_1_r == DG_W'(d)) ? word_s[(DIGITS-1-d)*4 +: 4] : nibble_s;
    end
  end

  // Stage 2: glyph row lookup.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_region_2_r <= 1'b0;
      rowbyte_2_r   <= 8'd0;
      hl_2_r        <= 1'b0;
      gcol_2_r      <= 3'd0;
      rgb_2_r       <= 24'd0;
      ce_2_r        <= 1'b0;
      en_2_r        <= 1'b0;
    end else begin
      in_region_2_r <= in_region_1_r;
      rowbyte_2_r   <= font_row(nibble_s, grow_1_r);
      hl_2_r        <= hl_s;
      gcol_2_r      <= gcol_1_r;
      rgb_2_r       <= rgb_1_r;
      ce_2_r        <= ce_1_r;
      en_2_r        <= en_1_r;
    end
  end

  // Stage 3: pixel pick and colour mix.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_rgb    <= 24'd0;
      o_ce_pix <= 1'b0;
    end else begin
      o_ce_pix <= ce_2_r;
      if (!en_2_r || !in_region_2_r) begin
        o_rgb <= rgb_2_r;
      end else if (rowbyte_2_r[~gcol_2_r]) begin
        o_rgb <= hl_2_r ? HL_COLOR : FG_COLOR;
      end else begin
        o_rgb <= BG_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_debug_hex_overlay.sv
// Directed bench for debug_hex_overlay: default instance plus a small 2x4 instance at origin.
module tb_debug_hex_overlay;

  localparam logic [23:0] FG = 24'hFFC000;
  localparam logic [23:0] HL = 24'hFF4040;
  localparam logic [23:0] BG = 24'h000040;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_enable;
  logic         i_freeze;
  logic         i_ce_pix;
  logic [11:0]  i_h;
  logic [11:0]  i_v;
  logic         i_vblank;
  logic [23:0]  i_rgb;
  logic [255:0] i_debug;
  logic [31:0]  dbg6;
  logic         o_ce_pix;
  logic [23:0]  o_rgb;
  logic         o6_ce_pix;
  logic [23:0]  o6_rgb;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  debug_hex_overlay u_dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_freeze(i_freeze),
    .i_ce_pix(i_ce_pix), .i_h(i_h), .i_v(i_v), .i_vblank(i_vblank),
    .i_rgb(i_rgb), .i_debug(i_debug), .o_ce_pix(o_ce_pix), .o_rgb(o_rgb)
  );

  debug_hex_overlay #(.CHANNELS(2), .DIGITS(4), .X0(0), .Y0(0)) u_small (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_freeze(i_freeze),
    .i_ce_pix(i_ce_pix), .i_h(i_h), .i_v(i_v), .i_vblank(i_vblank),
    .i_rgb(i_rgb), .i_debug(dbg6), .o_ce_pix(o6_ce_pix), .o_rgb(o6_rgb)
  );

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %06h expected %06h", tag, got, exp);
    end
  endtask

  // Present one pixel for a single clock, then different data, and stop right after the 3rd edge.
  task automatic drive_pix(input logic [11:0] h, input logic [11:0] v, input logic [23:0] rgb);
    @(negedge clk);
    i_h = h; i_v = v; i_rgb = rgb; i_ce_pix = 1'b1;
    @(negedge clk);
    i_h = 12'd0; i_v = 12'd0; i_rgb = ~rgb; i_ce_pix = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic vblank_pulse();
    @(negedge clk);
    i_vblank = 1'b1;
    @(negedge clk);
    i_vblank = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; i_enable = 1'b1; i_freeze = 1'b0; i_ce_pix = 1'b1;
    i_h = 12'd20; i_v = 12'd20; i_vblank = 1'b0; i_rgb = 24'h5A5A5A;
    i_debug = '0; dbg6 = 32'd0;

    // T1: reset state, then passthrough latency and empty snapshot
    repeat (4) @(posedge clk);
    #1;
    chk("reset_rgb", o_rgb, 24'h000000);
    chk("reset_ce", {23'd0, o_ce_pix}, 24'h000000);
    @(negedge clk);
    reset = 1'b0;
    drive_pix(12'd0, 12'd0, 24'h123456);
    chk("pass_rgb", o_rgb, 24'h123456);
    chk("pass_ce", {23'd0, o_ce_pix}, 24'h000001);
    drive_pix(12'd18, 12'd16, 24'h111111);
    chk("zero_snap_glyph", o_rgb, FG);

    // T2: load channel 0 and probe glyphs / region edges
    i_debug[63:0] = 64'h0123456789ABCDEF;
    vblank_pulse();
    drive_pix(12'd16, 12'd16, 24'h222222);
    chk("d0_row0_bit7", o_rgb, BG);
    drive_pix(12'd18, 12'd16, 24'h222222);
    chk("d0_row0_bit5", o_rgb, HL);
    drive_pix(12'd27, 12'd16, 24'h222222);
    chk("d1_row0_bit4", o_rgb, HL);
    drive_pix(12'd97, 12'd20, 24'h222222);
    chk("dA_row4_bit6", o_rgb, HL);
    drive_pix(12'd137, 12'd16, 24'h222222);
    chk("dF_row0_bit6", o_rgb, HL);
    drive_pix(12'd141, 12'd19, 24'h222222);
    chk("dF_row3_bit2", o_rgb, HL);
    drive_pix(12'd142, 12'd19, 24'h222222);
    chk("dF_row3_bit1", o_rgb, BG);
    drive_pix(12'd137, 12'd23, 24'h222222);
    chk("dF_row7", o_rgb, BG);
    drive_pix(12'd143, 12'd16, 24'h333333);
    chk("right_edge_in", o_rgb, BG);
    drive_pix(12'd144, 12'd16, 24'h333333);
    chk("right_edge_out", o_rgb, 24'h333333);
    drive_pix(12'd15, 12'd16, 24'h444444);
    chk("left_edge_out", o_rgb, 24'h444444);
    drive_pix(12'd16, 12'd15, 24'h555555);
    chk("top_edge_out", o_rgb, 24'h555555);
    drive_pix(12'd17, 12'd47, 24'h666666);
    chk("bottom_edge_in", o_rgb, BG);
    drive_pix(12'd17, 12'd48, 24'h666666);
    chk("bottom_edge_out", o_rgb, 24'h666666);

    // T3: freeze holds the snapshot across a vblank edge
    i_debug[63:0] = 64'hF123456789ABCDEF;
    i_freeze = 1'b1;
    vblank_pulse();
    i_freeze = 1'b0;
    drive_pix(12'd17, 12'd16, 24'h777777);
    chk("frozen_digit", o_rgb, BG);
    vblank_pulse();
    drive_pix(12'd17, 12'd16, 24'h777777);
    chk("unfrozen_digit", o_rgb, HL);

    // Run channel 0 hold down: 29 more edges still highlighted, the 30th clears it
    for (int i = 0; i < 29; i++) vblank_pulse();
    drive_pix(12'd17, 12'd16, 24'h888888);
    chk("ch0_hold_last", o_rgb, HL);
    vblank_pulse();
    drive_pix(12'd17, 12'd16, 24'h888888);
    chk("ch0_hold_expired", o_rgb, FG);

    // T4: change channel 2 once
    i_debug[191:128] = 64'h1000000000000000;
    vblank_pulse();
    drive_pix(12'd19, 12'd32, 24'h999999);
    chk("ch2_hl_edge1", o_rgb, HL);
    drive_pix(12'd17, 12'd16, 24'h999999);
    chk("ch0_stays_fg", o_rgb, FG);
    for (int i = 0; i < 29; i++) vblank_pulse();
    drive_pix(12'd19, 12'd32, 24'h999999);
    chk("ch2_hl_edge30", o_rgb, HL);
    vblank_pulse();
    drive_pix(12'd19, 12'd32, 24'h999999);
    chk("ch2_fg_edge31", o_rgb, FG);

    // T5: enable off is passthrough inside the block; glyph-off pixel shows background
    i_enable = 1'b0;
    drive_pix(12'd17, 12'd16, 24'hABCDEF);
    chk("disabled_pass", o_rgb, 24'hABCDEF);
    chk("disabled_ce", {23'd0, o_ce_pix}, 24'h000001);
    i_enable = 1'b1;
    drive_pix(12'd16, 12'd16, 24'h123123);
    chk("enabled_bg", o_rgb, BG);

    // T6: small instance at origin, 32x16 block
    drive_pix(12'd2, 12'd0, 24'hC0FFEE);
    chk("small_glyph", o6_rgb, FG);
    drive_pix(12'd31, 12'd15, 24'hC0FFEE);
    chk("small_corner_in", o6_rgb, BG);
    drive_pix(12'd32, 12'd15, 24'hC0FFEE);
    chk("small_h_out", o6_rgb, 24'hC0FFEE);
    drive_pix(12'd31, 12'd16, 24'hBEEF00);
    chk("small_v_out", o6_rgb, 24'hBEEF00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
